// File: rtl/snapshot_pkg.sv
// State encoding and default geometry shared by the parameter-RAM snapshot reader.
package snapshot_pkg;
  localparam int NUM_WORDS = 4;
  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 32;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;
endpackage

// File: rtl/mem_snapshot_reader.sv
// Sole master of the parameter RAM: forwards game-logic writes between frames and
// reads every word once per frame_start into an atomically updated snapshot.
module mem_snapshot_reader #(
  parameter int NUM_WORDS = snapshot_pkg::NUM_WORDS,
  parameter int ADDR_W    = snapshot_pkg::ADDR_W,
  parameter int DATA_W    = snapshot_pkg::DATA_W
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_frame_start,
  input  logic                        i_wr_req,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic [DATA_W-1:0]           i_wr_data,
  input  logic [DATA_W/8-1:0]         i_wr_be,
  output logic                        o_wr_ack,
  output logic [ADDR_W-1:0]           o_mem_address,
  output logic                        o_mem_chipselect,
  output logic                        o_mem_write,
  output logic [DATA_W/8-1:0]         o_mem_byteenable,
  output logic [DATA_W-1:0]           o_mem_writedata,
  output logic                        o_mem_clken,
  input  logic [DATA_W-1:0]           i_mem_readdata,
  output logic [NUM_WORDS*DATA_W-1:0] o_snapshot,
  output logic                        o_snapshot_valid,
  output logic                        o_busy,
  output logic                        o_overrun
);
  import snapshot_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_e                      r_state;
  state_e                      w_next;
  logic [ADDR_W-1:0]           r_cnt;
  logic                        r_pending;
  logic                        r_overrun;
  logic [DATA_W-1:0]           r_staging [NUM_WORDS-1];
  logic [NUM_WORDS*DATA_W-1:0] r_snapshot;
  logic                        r_snapshot_valid;
  logic                        r_wr_ack;
  logic                        r_busy;
  logic [ADDR_W-1:0]           r_wr_addr;
  logic [DATA_W-1:0]           r_wr_data;
  logic [DATA_W/8-1:0]         r_wr_be;
  logic                        w_start_read;
  logic                        w_set_pending;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // RAM port decodes from state, counter and write latch only, never from inputs.
  always_comb begin
    w_next           = r_state;
    o_mem_address    = '0;
    o_mem_chipselect = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_byteenable = '1;
    o_mem_writedata  = '0;
    unique case (r_state)
      IDLE: begin
        if (i_wr_req)                        w_next = WRITE;
        else if (i_frame_start || r_pending) w_next = READ;
      end
      WRITE: begin
        o_mem_address    = r_wr_addr;
        o_mem_chipselect = 1'b1;
        o_mem_write      = 1'b1;
        o_mem_byteenable = r_wr_be;
        o_mem_writedata  = r_wr_data;
        w_next           = r_pending ? READ : IDLE;
      end
      READ: begin
        o_mem_address    = r_cnt;
        o_mem_chipselect = 1'b1;
        if (r_cnt == LAST_ADDR) w_next = DRAIN;
      end
      DRAIN:   w_next = DONE;
      DONE:    w_next = r_pending ? READ : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_start_read  = (w_next == READ) && (r_state != READ);
  assign w_set_pending = i_frame_start && ((r_state != IDLE) || i_wr_req);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt            <= '0;
      r_pending        <= 1'b0;
      r_overrun        <= 1'b0;
      r_snapshot       <= '0;
      r_snapshot_valid <= 1'b0;
      r_wr_ack         <= 1'b0;
      r_busy           <= 1'b0;
      r_wr_addr        <= '0;
      r_wr_data        <= '0;
      r_wr_be          <= '0;
      for (int i = 0; i < NUM_WORDS - 1; i++) r_staging[i] <= '0;
    end else begin
      r_busy           <= (w_next != IDLE);
      r_snapshot_valid <= (w_next == DONE);
      r_wr_ack         <= (w_next == WRITE);

      if (r_state == IDLE && i_wr_req) begin
        r_wr_addr <= i_wr_addr;
        r_wr_data <= i_wr_data;
        r_wr_be   <= i_wr_be;
      end

      if (w_start_read)          r_cnt <= '0;
      else if (r_state == READ)  r_cnt <= r_cnt + 1'b1;

      // Read data lags the address by one cycle, hence the cnt-1 slot.
      if (r_state == READ && r_cnt != '0) r_staging[r_cnt - 1'b1] <= i_mem_readdata;

      if (r_state == DRAIN) begin
        for (int i = 0; i < NUM_WORDS - 1; i++) r_snapshot[i*DATA_W +: DATA_W] <= r_staging[i];
        r_snapshot[(NUM_WORDS-1)*DATA_W +: DATA_W] <= i_mem_readdata;
      end

      if (w_set_pending)     r_pending <= 1'b1;
      else if (w_start_read) r_pending <= 1'b0;

      if (i_frame_start && r_pending) r_overrun <= 1'b1;
    end
  end

  assign o_wr_ack         = r_wr_ack;
  assign o_mem_clken      = 1'b1;
  assign o_snapshot       = r_snapshot;
  assign o_snapshot_valid = r_snapshot_valid;
  assign o_busy           = r_busy;
  assign o_overrun        = r_overrun;
endmodule

// File: doc/mem_snapshot_reader.md
# mem_snapshot_reader

Downstream consumer of the 4-word, 32-bit on-chip parameter RAM (single-port, registered address, unregistered `q`, 1-cycle read latency). Once per `frame_start` pulse it reads all words in sequence and presents them to game logic as one atomically updated snapshot. Between frames it also forwards single-word write requests from game logic into the RAM. It is the sole master of the RAM's port.

## Interface
- `NUM_WORDS`, 4: words per snapshot; equals RAM depth.
- `ADDR_W`, 2: RAM address width, clog2(`NUM_WORDS`).
- `DATA_W`, 32: RAM word width; byte-enable width is `DATA_W/8`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `frame_start`  in  1  one-cycle request to take a snapshot (vsync-derived).
- `wr_req`  in  1  game-logic write request; held until `wr_ack`.
- `wr_addr`  in  `ADDR_W`  write word address.
- `wr_data`  in  `DATA_W`  write data.
- `wr_be`  in  `DATA_W/8`  write byte enables.
- `wr_ack`  out  1  one-cycle pulse; the write is performed this cycle.
- `mem_address`  out  `ADDR_W`  RAM address.
- `mem_chipselect`  out  1  RAM chip select.
- `mem_write`  out  1  RAM write strobe.
- `mem_byteenable`  out  `DATA_W/8`  RAM byte enables; all ones on reads.
- `mem_writedata`  out  `DATA_W`  RAM write data.
- `mem_clken`  out  1  RAM clock enable; constant 1.
- `mem_readdata`  in  `DATA_W`  RAM read data; valid the cycle after the address is presented.
- `snapshot`  out  `NUM_WORDS*DATA_W`  word i at bits [i*DATA_W +: DATA_W].
- `snapshot_valid`  out  1  one-cycle pulse; `snapshot` changed this cycle.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  sticky; set when a `frame_start` is dropped.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- **IDLE**
  - If `wr_req` is high, latch `wr_addr`, `wr_data` and `wr_be`, then go to WRITE.
  - Otherwise, if `frame_start` or the pending flag is set, clear pending, set `cnt`=0, and go to READ.
- **WRITE** (1 cycle)
  - Drive `mem_chipselect`=1, `mem_write`=1 and the latched address, data and enables; `wr_ack`=1.
  - Next state is READ if pending is set, else IDLE.
- **READ** (`NUM_WORDS` cycles)
  - Drive `mem_address`=`cnt`, `mem_chipselect`=1, `mem_write`=0; increment `cnt`.
  - When `cnt`≥1, capture `mem_readdata` into staging word `cnt`-1.
  - After the cycle with `cnt`=`NUM_WORDS`-1, go to DRAIN.
- **DRAIN** (1 cycle)
  - No RAM access.
  - At the end-of-cycle edge, copy the last word plus staging words 0..`NUM_WORDS`-2 into `snapshot` together.
- **DONE** (1 cycle)
  - `snapshot_valid`=1.
  - Next state is READ if pending is set (clear it, `cnt`=0), else IDLE.
- **Pending and overrun:** pending is a one-deep flag.
  - A `frame_start` outside IDLE, or in IDLE together with `wr_req`, sets pending.
  - A `frame_start` while pending is already set sets `overrun`.
- **Priority:** in IDLE, a write beats a snapshot. `wr_req` seen in any other state waits for IDLE.
- **`wr_ack` handshake:** the requester drops `wr_req` the cycle after `wr_ack`. A `wr_req` still high then is a new request.
- **Snapshot integrity:** `snapshot` never mixes two frames, and it is not updated by writes until the next snapshot.

## Timing
- `frame_start` high in cycle 0 (IDLE) gives:
  - READ in cycles 1–4, addresses 0,1,2,3;
  - `mem_readdata` words 0–3 valid in cycles 2–5;
  - DRAIN in cycle 5;
  - `snapshot` updated and `snapshot_valid`=1 in cycle 6.
- Latency from `frame_start` to `snapshot_valid` is 6 cycles; with a same-cycle write it is 7.
- Back-to-back frames from pending: the next READ starts in cycle 7.
- `wr_req` first high in cycle 0 (IDLE) gives `wr_ack` in cycle 1 and the RAM written at the end of cycle 1. A read in cycle ≥2 returns the new data.
- Reset (`reset_n`=0 at an edge, any state) forces:
  - state IDLE, `cnt` 0, pending 0;
  - `overrun` 0, `snapshot` all zeros, staging all zeros;
  - `snapshot_valid`, `wr_ack`, `busy` 0;
  - `mem_chipselect`, `mem_write`, `mem_address` 0;
  - `mem_byteenable` all ones, `mem_writedata` 0, `mem_clken` 1.
- A snapshot interrupted by reset is discarded.
- All outputs except `mem_*` are registered. `mem_*` decode from state, `cnt` and the write latch only; they never depend combinationally on inputs.

## Structure
- Package `snapshot_pkg` holds the state enum (IDLE, WRITE, READ, DRAIN, DONE) and the default constants `NUM_WORDS`, `ADDR_W`, `DATA_W`.
- Single module; no sub-module.
- The FSM, counter, staging registers and write latch all sit in `mem_snapshot_reader`.

## Test plan
- RAM model preloaded with 0x11111111, 0x22222222, 0x33333333, 0x44444444; pulse `frame_start` -> `snapshot_valid` exactly 6 cycles later, `snapshot` = {0x44444444,0x33333333,0x22222222,0x11111111}, `busy` high cycles 1–6.
- `wr_req` (addr 2, data 0xDEADBEEF, be 4'b0011) together with `frame_start` -> `wr_ack` next cycle, `snapshot_valid` at cycle 7, word2 = 0x3333BEEF.
- `frame_start` at cycle 0 and cycle 3 -> two `snapshot_valid` pulses (cycles 6 and 12), `overrun`=0. A third pulse at cycle 4 -> `overrun`=1.
- `wr_req` asserted in cycle 2 of a READ -> no write until IDLE, `wr_ack` in cycle 8, `snapshot` unchanged by the write.
- `reset_n` low for 1 cycle during cycle 3 of READ -> `snapshot` all zeros, no `snapshot_valid`, all outputs at reset values, next `frame_start` completes normally.
- After reset, idle for 20 cycles -> `mem_chipselect`=0 and `mem_clken`=1 throughout.
